// File: rtl/alu_seq_if.sv
// Request/result bundle for alu_seq.
// The master issues operations and consumes results; the slave is the ALU.
interface alu_seq_if #(parameter int len = 8);
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     op;
  logic [len-1:0] A;
  logic [len-1:0] B;
  logic           out_valid;
  logic           out_ready;
  logic [len-1:0] S;
  logic           carry;
  logic           zero;

  modport master (
    output in_valid, op, A, B, out_ready,
    input  in_ready, out_valid, S, carry, zero
  );

  modport slave (
    input  in_valid, op, A, B, out_ready,
    output in_ready, out_valid, S, carry, zero
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle add/sub, shifts at one bit per cycle, valid/ready on both sides.
// Define ALU_SEQ_FLAGS_EN to build the carry/zero flag logic; otherwise both flags read 0.
module alu_seq #(
  parameter int len = 8
) (
  input logic       clk,
  input logic       rst,
  alu_seq_if.slave  bus
);

  localparam int CW = $clog2(len + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_SHR = 2'd3;

  localparam logic [len-1:0] LEN_B = len'(len);
  localparam logic [CW-1:0]  LEN_C = CW'(len);

  logic [1:0]     state_q, state_d;
  logic [len-1:0] work_q,  work_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic           shr_q,   shr_d;
  logic [CW-1:0]  n_w;

  // Counts above len are clamped so the counter never wraps.
  function automatic logic [CW-1:0] clamp_count(input logic [len-1:0] b);
    if (b >= LEN_B) return LEN_C;
    return b[CW-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    shr_d   = shr_q;
    n_w     = clamp_count(bus.B);
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          shr_d = (bus.op == OP_SHR);
          case (bus.op)
            OP_ADD: begin
              work_d  = bus.A + bus.B;
              state_d = DONE;
            end
            OP_SUB: begin
              work_d  = bus.A - bus.B;
              state_d = DONE;
            end
            default: begin
              work_d  = bus.A;
              cnt_d   = n_w;
              state_d = (n_w == '0) ? DONE : EXEC;
            end
          endcase
        end
      end
      EXEC: begin
        work_d = shr_q ? (work_q >> 1) : (work_q << 1);
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      shr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      shr_q   <= shr_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.S         = work_q;

`ifdef ALU_SEQ_FLAGS_EN
  logic           carry_q, carry_d;
  logic           zero_q,  zero_d;
  logic [len:0]   sum_w;

  // Carry tracks the last bit shifted out; zero is captured on entry to DONE.
  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    sum_w   = {1'b0, bus.A} + {1'b0, bus.B};
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          case (bus.op)
            OP_ADD:  carry_d = sum_w[len];
            OP_SUB:  carry_d = (bus.A < bus.B);
            default: carry_d = 1'b0;
          endcase
        end
      end
      EXEC:    carry_d = shr_q ? work_q[0] : work_q[len-1];
      default: carry_d = carry_q;
    endcase
    if (state_d == DONE && state_q != DONE) zero_d = (work_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;
`else
  assign bus.carry = 1'b0;
  assign bus.zero  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (len = 8): directed vector table, random ops against an arithmetic model,
// backpressure and mid-shift reset sequences.
module tb_alu_seq;

  localparam int LEN = 8;
`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.len(LEN)) bus ();

  alu_seq #(.len(LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       z;
    int         lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference behaviour straight from the arithmetic definition of each op.
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] s, output logic c, output logic z, output int lat);
    int ai, bi, r, n;
    ai  = int'(a);
    bi  = int'(b);
    n   = (bi > LEN) ? LEN : bi;
    lat = 1;
    c   = 1'b0;
    case (op)
      2'd0: begin r = ai + bi; s = 8'(r); c = (r >= 256); end
      2'd1: begin r = ai - bi; s = 8'(r); c = (ai < bi); end
      2'd2: begin
        s = 8'(ai << n);
        if (n > 0) begin c = ((ai >> (LEN - n)) & 1) != 0; lat = n + 1; end
      end
      default: begin
        s = 8'(ai >> n);
        if (n > 0) begin c = ((ai >> (n - 1)) & 1) != 0; lat = n + 1; end
      end
    endcase
    z = (s == 8'h00);
  endtask

  // Issue one op from a negedge in IDLE; returns result and accept-to-out_valid latency.
  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] s, output logic c, output logic z, output int lat);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
    chk("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.op       = 2'($urandom);
    bus.A        = 8'($urandom);
    bus.B        = 8'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    s = bus.S;
    c = bus.carry;
    z = bus.zero;
    if (bus.out_ready) begin
      @(negedge clk);
      chk("in_ready_after_result", 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic check_result(input string tag, input logic [7:0] s, input logic c, input logic z,
                              input int lat, input logic [7:0] es, input logic ec,
                              input logic ez, input int elat);
    chk({tag, "_S"},       32'(s),   32'(es));
    chk({tag, "_carry"},   32'(c),   32'(FLAGS ? ec : 1'b0));
    chk({tag, "_zero"},    32'(z),   32'(FLAGS ? ez : 1'b0));
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
  endtask

  initial begin
    vec_t       vt[7];
    logic [7:0] s, es;
    logic       c, z, ec, ez;
    int         lat, elat;
    logic [1:0] rop;
    logic [7:0] ra, rb;

    vt[0] = '{op: 2'd0, a: 8'hF0, b: 8'h20, s: 8'h10, c: 1'b1, z: 1'b0, lat: 1};
    vt[1] = '{op: 2'd1, a: 8'h03, b: 8'h05, s: 8'hFE, c: 1'b1, z: 1'b0, lat: 1};
    vt[2] = '{op: 2'd1, a: 8'h05, b: 8'h05, s: 8'h00, c: 1'b0, z: 1'b1, lat: 1};
    vt[3] = '{op: 2'd2, a: 8'h81, b: 8'd3,  s: 8'h08, c: 1'b0, z: 1'b0, lat: 4};
    vt[4] = '{op: 2'd3, a: 8'h81, b: 8'd1,  s: 8'h40, c: 1'b1, z: 1'b0, lat: 2};
    vt[5] = '{op: 2'd3, a: 8'hFF, b: 8'd200, s: 8'h00, c: 1'b1, z: 1'b1, lat: 9};
    vt[6] = '{op: 2'd2, a: 8'h5A, b: 8'd0,  s: 8'h5A, c: 1'b0, z: 1'b0, lat: 1};

    bus.in_valid  = 1'b0;
    bus.op        = 2'd0;
    bus.A         = 8'h00;
    bus.B         = 8'h00;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_S",         32'(bus.S),         32'd0);
    chk("reset_carry",     32'(bus.carry),     32'd0);
    chk("reset_zero",      32'(bus.zero),      32'd0);

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, s, c, z, lat);
      check_result($sformatf("vec%0d", i), s, c, z, lat, vt[i].s, vt[i].c, vt[i].z, vt[i].lat);
    end

    // Backpressure: result must hold while out_ready is low.
    bus.out_ready = 1'b0;
    run_op(2'd0, 8'hF0, 8'h20, s, c, z, lat);
    check_result("bp", s, c, z, lat, 8'h10, 1'b1, 1'b0, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_S",         32'(bus.S),         32'h10);
      chk("bp_hold_carry",     32'(bus.carry),     32'(FLAGS));
      chk("bp_hold_zero",      32'(bus.zero),      32'd0);
      chk("bp_hold_in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp_hold_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the second EXEC cycle of a 6-bit left shift.
    bus.in_valid = 1'b1;
    bus.op       = 2'd2;
    bus.A        = 8'hFF;
    bus.B        = 8'd6;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midshift_exec_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midshift_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midshift_rst_S",         32'(bus.S),         32'd0);
    chk("midshift_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("midshift_rst_carry",     32'(bus.carry),     32'd0);
    run_op(2'd0, 8'h01, 8'h01, s, c, z, lat);
    check_result("after_rst_add", s, c, z, lat, 8'h02, 1'b0, 1'b0, 1);

    // Random operations against the model.
    for (int i = 0; i < 80; i++) begin
      rop = 2'($urandom);
      ra  = 8'($urandom);
      rb  = (rop[1] && ($urandom_range(0, 3) != 0)) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      model(rop, ra, rb, es, ec, ez, elat);
      run_op(rop, ra, rb, s, c, z, lat);
      check_result($sformatf("rand%0d_op%0d_a%0h_b%0h", i, rop, ra, rb),
                   s, c, z, lat, es, ec, ez, elat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter: len, default 8, operand/result width in bits; legal range len >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  operation request present.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: op  input  2  operation select: 00 add, 01 subtract, 10 shift left, 11 shift right.
REQ-007 Port: A  input  len  first operand; also the shift source.
REQ-008 Port: B  input  len  second operand for add/sub; unsigned shift count for shifts.
REQ-009 Port: out_valid  output  1  result present.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: S  output  len  result.
REQ-012 Port: carry  output  1  add carry-out / subtract borrow-out / last bit shifted out.
REQ-013 Port: zero  output  1  S equals 0.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-015 Accept SHALL occur on a cycle with in_valid & in_ready; op, A and B are latched and are ignored at all other times.
REQ-016 Add SHALL compute S = (A + B) mod 2^len, with carry = bit len of the full sum; IDLE -> DONE, so out_valid asserts 1 cycle after accept.
REQ-017 Subtract SHALL compute S = (A - B) mod 2^len, with carry = 1 iff A < B (unsigned borrow); IDLE -> DONE, latency 1.
REQ-018 Shifts SHALL take effective count n = min(B, len) and are zero-fill logical shifts.
REQ-019 Shift with n = 0: IDLE -> DONE, S = A, carry = 0, latency 1.
REQ-020 Shift with n >= 1: IDLE -> EXEC; EXEC shifts the working register by exactly one bit per cycle for n cycles, then goes to DONE; out_valid asserts n+1 cycles after accept.
REQ-021 During a shift, carry SHALL capture the bit shifted out in each EXEC cycle, so the final value is the last bit shifted out (shift left: A[len-n]; shift right: A[n-1]).
REQ-022 The shift counter SHALL be $clog2(len+1) bits wide; B values above len SHALL NOT wrap the counter.
REQ-023 In DONE, S, carry and zero SHALL hold stable until out_valid & out_ready; DONE -> IDLE on that handshake, so in_ready rises the following cycle.
REQ-024 Back-to-back throughput: at most one operation in flight; there is no overlap of accept and result.
REQ-025 S, carry and zero values outside DONE are don't-care for the consumer, but SHALL be deterministic (no X after reset).

Reset
REQ-026 When rst is high at a clock edge, the FSM SHALL go to IDLE and S, carry, zero, out_valid and the shift counter SHALL be cleared to 0; in_ready = 1 on the next cycle.
REQ-027 rst SHALL override any handshake in the same cycle; an operation in EXEC or DONE is abandoned and produces no result.

Configuration
REQ-028 Macro ALU_SEQ_FLAGS_EN: when defined, carry and zero SHALL behave per REQ-012/013/016-021; when undefined, both ports SHALL be driven constant 0 and no flag logic is synthesised. S and timing SHALL be identical in both builds.

Verification (len = 8, ALU_SEQ_FLAGS_EN defined)
REQ-029 Add A=0xF0, B=0x20 -> S=0x10, carry=1, zero=0, out_valid 1 cycle after accept.
REQ-030 Sub A=0x03, B=0x05 -> S=0xFE, carry=1; sub A=0x05, B=0x05 -> S=0x00, carry=0, zero=1.
REQ-031 Shl A=0x81, B=3 -> S=0x08, carry=0, out_valid 4 cycles after accept; shr A=0x81, B=1 -> S=0x40, carry=1, latency 2; shr A=0xFF, B=200 -> S=0x00, carry=1, zero=1, latency 9.
REQ-032 Backpressure: add result with out_ready low for 5 cycles -> S and flags unchanged, in_ready=0 throughout; out_ready high -> IDLE, in_ready=1 on the next cycle.
REQ-033 Reset mid-shift: assert rst in the 2nd EXEC cycle of shl B=6 -> next cycle IDLE, out_valid=0, S=0, in_ready=1; a following add of 1+1 returns S=0x02.
REQ-034 Build without ALU_SEQ_FLAGS_EN: rerun REQ-029 -> S=0x10 with identical timing, carry=0, zero=0.
